// File: rtl/cgu_divn.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cgu_divn                                                        |
// | Purpose  : NCH-channel clock-enable / divided-clock generator. Each        |
// |            channel picks an event source (every cycle, or the synchronised |
// |            rising edge of one src bit), counts div+1 events per tick and   |
// |            toggles a 50%-duty level on every tick.                         |
// | Ports    : c_clk/c_rstb   clock, async active-low reset                    |
// |            scan_mode      forces lck = c_clk                               |
// |            src            asynchronous event sources                       |
// |            tick, lck      per-channel pulse and divided level              |
// |            c_valid..c_ready  single-cycle config register port            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cgu_divn #(
  parameter int NCH  = 4,
  parameter int NSRC = 36,
  parameter int DW   = 16,
  parameter int SW   = 6
) (
  input  logic              c_clk,
  input  logic              c_rstb,
  input  logic              scan_mode,
  input  logic [NSRC-1:0]   src,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    lck,
  input  logic              c_valid,
  input  logic              c_write,
  input  logic [31:0]       c_addr,
  input  logic [1:0]        c_size,
  input  logic [31:0]       c_wdata,
  output logic [31:0]       c_rdata,
  output logic              c_ready
);

  localparam logic [31:0] c_ctrl_addr   = 32'h0000_0000;
  localparam logic [31:0] c_status_addr = 32'h0000_0004;
  localparam logic [31:0] c_info_addr   = 32'h0000_0008;
  localparam logic [31:0] c_ch_base     = 32'h0000_0010;
  localparam logic [31:0] c_ch_end      = c_ch_base + 32'(8 * NCH);
  localparam logic [31:0] c_info        = {8'd0, 8'(DW), 8'(NSRC), 8'(NCH)};

  // ---------------- source synchroniser and edge detect ----------------
  logic [NSRC-1:0] r_sync1, r_sync2, r_sync3, r_edge;
  logic [2**SW-1:0] w_ev_vec;

  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Select index 0 = every cycle, 1..NSRC = edge of src[sel-1], above = never.
  always_comb begin
    w_ev_vec         = '0;
    w_ev_vec[NSRC:0] = {r_edge, 1'b1};
  end

  // ---------------- bus decode ----------------
  logic [31:0] w_word_addr, w_wd, w_off, w_rd_word;
  logic        w_wr, w_rd, w_in_ch, w_is_div, w_ctrl_wr, w_status_wr;
  logic [2:0]  w_idx;

  assign w_word_addr = {c_addr[31:2], 2'b00};
  assign w_wd        = c_wdata << {c_addr[1:0], 3'b000};
  assign w_off       = w_word_addr - c_ch_base;
  assign w_wr        = c_valid & c_write;
  assign w_rd        = c_valid & ~c_write;
  assign w_in_ch     = (w_word_addr >= c_ch_base) && (w_word_addr < c_ch_end);
  assign w_idx       = w_off[5:3];
  assign w_is_div    = w_off[2];
  assign w_ctrl_wr   = w_wr && (w_word_addr == c_ctrl_addr);
  assign w_status_wr = w_wr && (w_word_addr == c_status_addr);

  // ---------------- channels ----------------
  logic [SW-1:0]  w_sel [NCH];
  logic [DW-1:0]  w_div [NCH];
  logic [NCH-1:0] r_en, r_status, w_fire;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [SW-1:0] r_sel;
    logic [DW-1:0] r_div, r_cnt;
    logic          r_tg, r_tick;
    logic          w_hit_cfg, w_hit_div, w_restart, w_ev;

    assign w_hit_cfg = w_wr && w_in_ch && (w_idx == 3'(n)) && !w_is_div;
    assign w_hit_div = w_wr && w_in_ch && (w_idx == 3'(n)) && w_is_div;
    assign w_restart = w_hit_cfg || w_hit_div || (w_ctrl_wr && w_wd[16+n]);
    assign w_ev      = w_ev_vec[r_sel];
    assign w_fire[n] = r_en[n] && !w_restart && w_ev && (r_cnt == r_div);

    always_ff @(posedge c_clk or negedge c_rstb) begin
      if (!c_rstb) begin
        r_sel  <= SW'(n + 1);
        r_div  <= '0;
        r_cnt  <= '0;
        r_tg   <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (w_hit_cfg) r_sel <= w_wd[SW-1:0];
        if (w_hit_div) r_div <= w_wd[DW-1:0];
        // A config write or rst pulse restarts the phase with no tick.
        if (w_restart || !r_en[n]) begin
          r_cnt  <= '0;
          r_tg   <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_tick <= w_fire[n];
          if (w_fire[n]) begin
            r_cnt <= '0;
            r_tg  <= ~r_tg;
          end else if (w_ev) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign w_sel[n] = r_sel;
    assign w_div[n] = r_div;
    assign tick[n]  = r_tick;
    assign lck[n]   = scan_mode ? c_clk : r_tg;
  end

  // ---------------- read mux ----------------
  always_comb begin
    w_rd_word = '0;
    if (w_word_addr == c_ctrl_addr) begin
      w_rd_word[NCH-1:0] = r_en;
    end else if (w_word_addr == c_status_addr) begin
      w_rd_word[NCH-1:0] = r_status;
    end else if (w_word_addr == c_info_addr) begin
      w_rd_word = c_info;
    end else if (w_in_ch) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_idx == 3'(i)) begin
          if (w_is_div) w_rd_word[DW-1:0] = w_div[i];
          else          w_rd_word[SW-1:0] = w_sel[i];
        end
      end
    end
  end

  // ---------------- control/status and bus response ----------------
  logic [31:0] r_rdata;
  logic [1:0]  r_lane;
  logic        r_ready;
  logic [NCH-1:0] w_clr;

  assign w_clr = w_status_wr ? w_wd[NCH-1:0] : '0;

  always_ff @(posedge c_clk or negedge c_rstb) begin
    if (!c_rstb) begin
      r_en     <= '0;
      r_status <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_lane   <= 2'b00;
    end else begin
      r_ready <= c_valid;
      if (w_rd) begin
        r_rdata <= w_rd_word;
        r_lane  <= c_addr[1:0];
      end
      if (w_ctrl_wr) r_en <= w_wd[NCH-1:0];
      // Set beats clear when both land in the same cycle.
      r_status <= (r_status & ~w_clr) | w_fire;
    end
  end

  assign c_rdata = r_rdata >> {r_lane, 3'b000};
  assign c_ready = r_ready;

  logic w_unused;
  assign w_unused = ^{c_size, w_off[31:6], w_off[1:0], w_wd};

endmodule
`default_nettype wire

// File: doc/cgu_divn.md
Name: cgu_divn

Overview:
- Parametrised clock-enable and divided-clock generator for the bus subsystem.
- Offers NCH independent channels. Each channel selects an event source (c_clk itself or any synchronised rtc/fclk bit), divides it by a programmable integer, and emits a one-cycle tick plus a 50%-duty divided level.
- Fully synchronous to c_clk; configured through the standard c_* register port.

Parameters:
- NCH, 4, number of output channels (1..8).
- NSRC, 36, width of src input vector (rtc concatenated with fclk).
- DW, 16, divider counter width (2..24).
- SW, 6, source-select field width; must satisfy 2^SW > NSRC.

Ports:
- c_clk  input  1  block clock.
- c_rstb  input  1  asynchronous active-low reset.
- scan_mode  input  1  test mode; forces lck = c_clk.
- src  input  NSRC  asynchronous event sources.
- tick  output  NCH  one-cycle enable pulse per channel.
- lck  output  NCH  divided-clock level per channel.
- c_valid  input  1  config access request.
- c_write  input  1  1 = write, 0 = read.
- c_addr  input  32  byte address.
- c_size  input  2  access size; ignored, full-word semantics after lane shift.
- c_wdata  input  32  write data.
- c_rdata  output  32  read data.
- c_ready  output  1  access complete.

Behaviour:
- Reset (c_rstb low, asynchronous):
  - tick=0, c_ready=0, c_rdata register=0.
  - All counters and toggles = 0, CTRL=0, STATUS=0.
  - sel_n = n+1 (channel n follows src[n]); div_n = 0.
- Synchroniser: each src bit passes through 2 flops then a rising-edge detector.
  - Source event for channel n is: 1 every cycle if sel_n==0; edge(src[sel_n-1]) if 1<=sel_n<=NSRC; never if sel_n>NSRC.
- Channel counter (cnt_n, DW bits), when enabled:
  - On an event with cnt_n==div_n: cnt_n<=0, tick_n<=1 for exactly one cycle (registered, one cycle after the event cycle), tg_n<=~tg_n.
  - On an event with cnt_n!=div_n: cnt_n<=cnt_n+1.
  - tick period = (div_n+1) events; lck period = 2*(div_n+1) events.
  - div_n=0 with sel_n=0 gives tick held high and lck = c_clk/2.
- Disabled channel (CTRL.en_n=0): cnt_n, tg_n and tick_n held at 0.
- lck_n = scan_mode ? c_clk : tg_n (combinational mux only). tick is unaffected by scan_mode.
- Restart: counter and toggle reset to 0 the cycle after any of the following, with no tick in that cycle:
  - a write to CFG_n or DIV_n;
  - writing 1 to CTRL.rst_n.
- Register map (word address = c_addr & ~3):
  - 0x00 CTRL: [NCH-1:0] en, rw. [16+n] rst_n, write-1 pulse, reads 0.
  - 0x04 STATUS: [NCH-1:0] sticky tick flags, write-1-to-clear. A hardware set in the same cycle as a clear wins (flag stays 1).
  - 0x08 INFO: read-only {8'd0, DW[7:0], NSRC[7:0], NCH[7:0]}.
  - 0x10+8n CFG_n: [SW-1:0] sel_n, rw.
  - 0x14+8n DIV_n: [DW-1:0] div_n, rw.
  - Unmapped or n>=NCH: reads 0, writes ignored. Upper unused bits read 0.
- Bus handshake:
  - c_ready <= c_valid every cycle; one-cycle latency, no wait states.
  - The read value is captured into the c_rdata register in the c_valid cycle and is valid while c_ready=1.
  - Byte lanes: effective write data = c_wdata << 8*c_addr[1:0]; c_rdata = rdata_reg >> 8*c_addr[1:0].
  - Back-to-back c_valid cycles are each serviced.
- Reset mid-operation clears everything immediately. After c_rstb rises, the first src edge needs 2 synchroniser cycles plus 1 detect cycle before it counts.

Test Plan:
- Reset, then read 0x10 and 0x14 -> c_rdata=1 and 0. Read 0x08 with defaults -> 0x00102404. tick=0, lck=0.
- sel_0=0, div_0=3, en_0=1 -> tick[0] high 1 of every 4 c_clk cycles; lck[0] toggles every 4 cycles (period 8).
- sel_1=5 (src[4]), div_1=1, drive 6 src[4] rising edges -> 3 tick[1] pulses, each 3 c_clk cycles after its qualifying edge. STATUS[1]=1; W1C 0x2 -> 0, unless a tick occurs in the same cycle.
- During counting, write DIV_0 -> next cycle cnt=0, lck[0]=0, no tick that cycle. Write CTRL bit16 -> same restart.
- scan_mode=1 -> lck all follow c_clk while tick continues unchanged. sel_n=63 -> no ticks ever.
- Byte write c_addr=0x15, c_wdata=0x12 -> div_0[15:8]=0x12 written. Read at 0x15 returns div_0>>8. Read at unmapped 0x40 -> 0. Assert c_rstb mid-count -> all outputs 0 immediately.
